// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU bundle shared between the ALU arbiter and its requesters.
// slave = arbiter side; master = requesters plus the combinational ALU.
interface alu_share_arbiter_if #(
  parameter int RESULT_W = 32
);
  logic                req0_valid;
  logic                req0_ready;
  logic [3:0]          req0_ctl;
  logic [RESULT_W-1:0] req0_a;
  logic [RESULT_W-1:0] req0_b;
  logic                req1_valid;
  logic                req1_ready;
  logic [3:0]          req1_ctl;
  logic [RESULT_W-1:0] req1_a;
  logic [RESULT_W-1:0] req1_b;
  logic                resp0_valid;
  logic                resp0_ready;
  logic                resp1_valid;
  logic                resp1_ready;
  logic [RESULT_W-1:0] resp_result;
  logic                resp_zero;
  logic [3:0]          alu_ctl;
  logic [RESULT_W-1:0] alu_a;
  logic [RESULT_W-1:0] alu_b;
  logic [RESULT_W-1:0] alu_result;
  logic                alu_zero;
  logic                busy;

  modport slave (
    input  req0_valid, req0_ctl, req0_a, req0_b,
    input  req1_valid, req1_ctl, req1_a, req1_b,
    input  resp0_ready, resp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output resp_result, resp_zero, alu_ctl, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req0_ctl, req0_a, req0_b,
    output req1_valid, req1_ctl, req1_a, req1_b,
    output resp0_ready, resp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  resp_result, resp_zero, alu_ctl, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional per-requester accept counters when ALU_ARB_PERF_CNT_EN is defined.
module alu_share_arbiter #(
  parameter int ALU_LAT  = 1,
  parameter int RESULT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [15:0]        grant_cnt0,
  output logic [15:0]        grant_cnt1
`endif
);

  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
    $error("alu_share_arbiter: ALU_LAT=%0d outside 1..15", ALU_LAT);
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic                rr_ptr_q;
  logic                owner_q;
  logic [3:0]          cnt_q;
  logic [3:0]          alu_ctl_q;
  logic [RESULT_W-1:0] alu_a_q, alu_b_q;
  logic [RESULT_W-1:0] result_q;
  logic                zero_q;
  logic                resp0_vld_q, resp1_vld_q;

  logic grant0, grant1, any_valid, accept, own_resp_ready;

  // Tie goes to the pointer, which always names the requester not served last.
  assign grant0    = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
  assign grant1    = bus.req1_valid & (~bus.req0_valid |  rr_ptr_q);
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign accept    = (state_q == IDLE) & any_valid;
  assign own_resp_ready = owner_q ? bus.resp1_ready : bus.resp0_ready;

  assign bus.req0_ready  = (state_q == IDLE) & grant0;
  assign bus.req1_ready  = (state_q == IDLE) & grant1;
  assign bus.resp0_valid = resp0_vld_q;
  assign bus.resp1_valid = resp1_vld_q;
  assign bus.resp_result = result_q;
  assign bus.resp_zero   = zero_q;
  assign bus.alu_ctl     = alu_ctl_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid)       state_d = EXEC;
      EXEC:    if (cnt_q == 4'd0)   state_d = RESP;
      RESP:    if (own_resp_ready)  state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // ALU drive registers only load on accept, so the ALU sits quiet between ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      alu_ctl_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      resp0_vld_q <= 1'b0;
      resp1_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          alu_ctl_q <= grant1 ? bus.req1_ctl : bus.req0_ctl;
          alu_a_q   <= grant1 ? bus.req1_a   : bus.req0_a;
          alu_b_q   <= grant1 ? bus.req1_b   : bus.req0_b;
          owner_q   <= grant1;
          cnt_q     <= 4'(ALU_LAT - 1);
        end
        EXEC: if (cnt_q == 4'd0) begin
          result_q    <= bus.alu_result;
          zero_q      <= bus.alu_zero;
          resp0_vld_q <= ~owner_q;
          resp1_vld_q <=  owner_q;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: if (own_resp_ready) begin
          resp0_vld_q <= 1'b0;
          resp1_vld_q <= 1'b0;
          rr_ptr_q    <= ~owner_q;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      if (accept && !grant1 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (accept &&  grant1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule
